// File: rtl/issue_dispatch.sv
// Dual-issue dispatch buffer between ID and Issue_EXE: circular FIFO with pairwise hazard check.
// Latency: an entry pushed on edge N can issue combinationally in cycle N+1 (one register stage).
// Backpressure: in_ready is low when fewer than two slots are free; stall_DCache blocks issue but not fill.

package issue_dispatch_pkg;

  // Decoded instruction record exchanged between ID, this buffer and Issue_EXE.
  typedef struct packed {
    logic        o_valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [2:0]  br_type;
    logic        mem_we;
    logic [3:0]  ldst_type;
  } PC_set;

endpackage

module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int DEPTH = 8  // must be a power of two, at least 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  PC_set      in_set1,
  input  PC_set      in_set2,
  output logic       in_ready,
  input  logic       flush_BR,
  input  logic       stall_DCache,
  output PC_set      out_set1,
  output PC_set      out_set2,
  output logic [3:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;

  ptr_t          head_q;
  ptr_t          tail_q;
  logic [CW-1:0] count_q;
  PC_set         mem_q [DEPTH];

  PC_set         ent_a;
  PC_set         ent_b;
  logic          issue_a;
  logic          issue_b;
  logic          hazard;
  logic          push_en;
  logic          push_a;
  logic          push_b;
  logic [1:0]    n_push;
  logic [1:0]    n_pop;

  // A memory op is a store or any load/store type encoded in the low three bits.
  function automatic logic is_mem(input PC_set s);
    return s.mem_we || (s.ldst_type[2:0] != 3'd0);
  endfunction

  // Readiness is taken from the registered count only, so it never depends on this cycle's pops.
  always_comb begin
    in_ready  = (count_q <= CW'(DEPTH - 2));
    occupancy = 4'(count_q);
  end

  // Head pair is read straight out of the array; head+1 wraps naturally in a power-of-two pointer.
  always_comb begin
    ent_a = mem_q[head_q];
    ent_b = mem_q[head_q + ptr_t'(1)];
  end

  // Pairwise legality: RAW on B's sources, branch in A, two memory ops, or WAW on a real register.
  always_comb begin
    hazard = 1'b0;
    if (ent_a.rf_we && (ent_a.rf_rd != 5'd0) &&
        ((ent_a.rf_rd == ent_b.rf_raddr1) || (ent_a.rf_rd == ent_b.rf_raddr2)))
      hazard = 1'b1;
    if (ent_a.br_type != 3'd0)
      hazard = 1'b1;
    if (is_mem(ent_a) && is_mem(ent_b))
      hazard = 1'b1;
    if (ent_a.rf_we && ent_b.rf_we && (ent_a.rf_rd == ent_b.rf_rd) && (ent_a.rf_rd != 5'd0))
      hazard = 1'b1;
  end

  // Issue decision: flush and stall both suppress issue; B only goes out alongside a legal A.
  always_comb begin
    issue_a = (count_q != '0) && !stall_DCache && !flush_BR;
    issue_b = issue_a && (count_q >= CW'(2)) && !hazard;
    n_pop   = {1'b0, issue_a} + {1'b0, issue_b};
  end

  // Output records carry the stored fields with o_valid replaced by the issue decision.
  always_comb begin
    out_set1         = ent_a;
    out_set1.o_valid = issue_a;
    out_set2         = ent_b;
    out_set2.o_valid = issue_b;
  end

  // Push qualification: both slots must be free and no flush may be pending this cycle.
  always_comb begin
    push_en = in_ready && !flush_BR;
    push_a  = push_en && in_set1.o_valid;
    push_b  = push_en && in_set2.o_valid;
    n_push  = {1'b0, push_a} + {1'b0, push_b};
  end

  // Entry storage: valid inputs are compacted so a lone in_set2 lands at tail.
  always_ff @(posedge clk) begin
    if (push_a)
      mem_q[tail_q] <= in_set1;
    if (push_b)
      mem_q[tail_q + ptr_t'(push_a)] <= in_set2;
  end

  // Pointer and count update; flush empties the buffer and drops any same-cycle push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_BR) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + ptr_t'(n_pop);
      tail_q  <= tail_q + ptr_t'(n_push);
      count_q <= count_q + CW'(n_push) - CW'(n_pop);
    end
  end

endmodule

// File: tb/tb_issue_dispatch.sv
// Scoreboard bench for issue_dispatch: directed scenarios followed by randomized traffic.
// Expected entries are queued as the stimulus is accepted and popped when the DUT issues.
// Outputs are checked mid-cycle, away from the rising edge.

module tb_issue_dispatch;
  import issue_dispatch_pkg::*;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rstn;
  PC_set      in_set1;
  PC_set      in_set2;
  logic       in_ready;
  logic       flush_BR;
  logic       stall_DCache;
  PC_set      out_set1;
  PC_set      out_set2;
  logic [3:0] occupancy;

  int checks;
  int errors;

  PC_set exp_q[$];

  issue_dispatch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_set1      (in_set1),
    .in_set2      (in_set2),
    .in_ready     (in_ready),
    .flush_BR     (flush_BR),
    .stall_DCache (stall_DCache),
    .out_set1     (out_set1),
    .out_set2     (out_set2),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, got, req, $time);
    end
  endtask

  function automatic PC_set strip(input PC_set s);
    PC_set r;
    r = s;
    r.o_valid = 1'b0;
    return r;
  endfunction

  function automatic bit mem_op(input PC_set s);
    return s.mem_we || (s.ldst_type[2:0] != 3'd0);
  endfunction

  // Dual issue is allowed unless one of the listed pair hazards is present.
  function automatic bit pair_ok(input PC_set a, input PC_set b);
    if (a.rf_we && a.rf_rd != 0 && (a.rf_rd == b.rf_raddr1 || a.rf_rd == b.rf_raddr2)) return 0;
    if (a.br_type != 0) return 0;
    if (mem_op(a) && mem_op(b)) return 0;
    if (a.rf_we && b.rf_we && a.rf_rd == b.rf_rd && a.rf_rd != 0) return 0;
    return 1;
  endfunction

  function automatic PC_set mk(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] br,
                               input logic mwe, input logic [3:0] ldst);
    PC_set s;
    s.o_valid = 1'b1; s.pc = pc; s.rf_we = we; s.rf_rd = rd;
    s.rf_raddr1 = r1; s.rf_raddr2 = r2; s.br_type = br; s.mem_we = mwe; s.ldst_type = ldst;
    return s;
  endfunction

  function automatic PC_set rand_inst();
    PC_set s;
    s.o_valid   = ($urandom_range(0, 3) != 0);
    s.pc        = $urandom;
    s.rf_we     = $urandom_range(0, 1);
    s.rf_rd     = 5'($urandom_range(0, 3));
    s.rf_raddr1 = 5'($urandom_range(0, 3));
    s.rf_raddr2 = 5'($urandom_range(0, 3));
    s.br_type   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    s.mem_we    = ($urandom_range(0, 4) == 0);
    s.ldst_type = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : {$urandom_range(0, 1) == 1, 3'b000};
    return s;
  endfunction

  // Monitor and reference model: compare against the queued expectations, then advance the model.
  always @(negedge clk) begin
    int cnt;
    bit e1, e2;
    if (!rstn) begin
      exp_q.delete();
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_v1", 64'(out_set1.o_valid), 64'd0);
      chk("rst_v2", 64'(out_set2.o_valid), 64'd0);
    end else begin
      cnt = exp_q.size();
      e1 = (cnt >= 1) && !stall_DCache && !flush_BR;
      e2 = e1 && (cnt >= 2) && pair_ok(exp_q[0], exp_q[1]);
      chk("occupancy", 64'(occupancy), 64'(cnt));
      chk("in_ready", 64'(in_ready), 64'((DEPTH - cnt) >= 2));
      chk("out1_valid", 64'(out_set1.o_valid), 64'(e1));
      chk("out2_valid", 64'(out_set2.o_valid), 64'(e2));
      if (e1 && out_set1.o_valid) chk("out1_entry", 64'(strip(out_set1)), 64'(exp_q[0]));
      if (e2 && out_set2.o_valid) chk("out2_entry", 64'(strip(out_set2)), 64'(exp_q[1]));
      if (flush_BR) begin
        exp_q.delete();
      end else begin
        if (e1) void'(exp_q.pop_front());
        if (e2) void'(exp_q.pop_front());
        if ((DEPTH - cnt) >= 2) begin
          if (in_set1.o_valid) exp_q.push_back(strip(in_set1));
          if (in_set2.o_valid) exp_q.push_back(strip(in_set2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input PC_set a, input PC_set b, input logic st, input logic fl);
    in_set1 = a; in_set2 = b; stall_DCache = st; flush_BR = fl;
  endtask

  PC_set idle;
  PC_set a, b, c, d;

  initial begin
    checks = 0; errors = 0;
    idle = '0;
    rstn = 1'b0;
    drive(idle, idle, 1'b0, 1'b0);
    repeat (3) tick();
    rstn = 1'b1;

    // Independent pair issues together the cycle after it is pushed.
    a = mk(32'h1C000000, 1, 4, 0, 0, 0, 0, 0);
    b = mk(32'h1C000004, 0, 0, 5, 0, 0, 0, 0);
    drive(a, b, 0, 0); tick(); drive(idle, idle, 0, 0); #3;
    chk("d028_v1", 64'(out_set1.o_valid), 64'd1);
    chk("d028_v2", 64'(out_set2.o_valid), 64'd1);
    chk("d028_pc1", 64'(out_set1.pc), 64'h1C000000);
    chk("d028_pc2", 64'(out_set2.pc), 64'h1C000004);
    tick(); #3;
    chk("d028_occ", 64'(occupancy), 64'd0);

    // RAW through raddr2 forces single issue; B follows alone.
    a = mk(32'h1C000010, 1, 4, 0, 0, 0, 0, 0);
    b = mk(32'h1C000014, 0, 0, 0, 4, 0, 0, 0);
    drive(a, b, 0, 0); tick(); drive(idle, idle, 0, 0); #3;
    chk("d029_v1", 64'(out_set1.o_valid), 64'd1);
    chk("d029_v2", 64'(out_set2.o_valid), 64'd0);
    tick(); #3;
    chk("d029_b_v1", 64'(out_set1.o_valid), 64'd1);
    chk("d029_b_pc", 64'(out_set1.pc), 64'h1C000014);
    tick();

    // Fill under stall through the pointer wrap, drop an extra pair, then drain two per cycle.
    for (int i = 0; i < 5; i++) begin
      a = mk(32'h2000_0000 + 32'(8 * i), 1, 5'(2 * i + 1), 0, 0, 0, 0, 0);
      b = mk(32'h2000_0004 + 32'(8 * i), 1, 5'(2 * i + 2), 0, 0, 0, 0, 0);
      drive(a, b, 1, 0); tick(); #3;
      if (i == 2) begin
        chk("d030_occ6", 64'(occupancy), 64'd6);
        chk("d030_rdy6", 64'(in_ready), 64'd1);
      end
      if (i >= 3) begin
        chk("d030_occ8", 64'(occupancy), 64'd8);
        chk("d030_rdy8", 64'(in_ready), 64'd0);
      end
    end
    drive(idle, idle, 0, 0); #3;
    chk("d030_v2", 64'(out_set2.o_valid), 64'd1);
    chk("d030_pc1", 64'(out_set1.pc), 64'h2000_0000);
    for (int k = 1; k <= 4; k++) begin
      tick(); #3;
      chk("d030_drain", 64'(occupancy), 64'(8 - 2 * k));
    end

    // Load followed by store, then branch followed by plain op: each pair issues singly.
    a = mk(32'h3000_0000, 1, 6, 0, 0, 0, 0, 4'd1);
    b = mk(32'h3000_0004, 0, 0, 7, 8, 0, 1, 4'd2);
    drive(a, b, 0, 0); tick(); drive(idle, idle, 0, 0); #3;
    chk("d031_ldst_v2", 64'(out_set2.o_valid), 64'd0);
    tick(); #3;
    chk("d031_st_pc", 64'(out_set1.pc), 64'h3000_0004);
    tick();
    c = mk(32'h3000_0008, 0, 0, 1, 2, 1, 0, 0);
    d = mk(32'h3000_000C, 1, 9, 3, 3, 0, 0, 0);
    drive(c, d, 0, 0); tick(); drive(idle, idle, 0, 0); #3;
    chk("d031_br_v2", 64'(out_set2.o_valid), 64'd0);
    tick(); #3;
    chk("d031_d_pc", 64'(out_set1.pc), 64'h3000_000C);
    tick();

    // Flush with five entries, valid inputs and stall: nothing issues, buffer empties.
    drive(mk(32'h4000_0000, 0, 0, 0, 0, 0, 0, 0), mk(32'h4000_0004, 0, 0, 0, 0, 0, 0, 0), 1, 0); tick();
    drive(mk(32'h4000_0008, 0, 0, 0, 0, 0, 0, 0), mk(32'h4000_000C, 0, 0, 0, 0, 0, 0, 0), 1, 0); tick();
    drive(mk(32'h4000_0010, 0, 0, 0, 0, 0, 0, 0), idle, 1, 0); tick();
    drive(mk(32'h4000_0014, 0, 0, 0, 0, 0, 0, 0), mk(32'h4000_0018, 0, 0, 0, 0, 0, 0, 0), 1, 1); #3;
    chk("d032_occ5", 64'(occupancy), 64'd5);
    chk("d032_v1", 64'(out_set1.o_valid), 64'd0);
    chk("d032_v2", 64'(out_set2.o_valid), 64'd0);
    tick(); drive(idle, idle, 0, 0); #3;
    chk("d032_occ0", 64'(occupancy), 64'd0);
    chk("d032_rdy", 64'(in_ready), 64'd1);

    // Asynchronous reset between edges clears the buffer immediately.
    drive(mk(32'h5000_0000, 0, 0, 0, 0, 0, 0, 0), mk(32'h5000_0004, 0, 0, 0, 0, 0, 0, 0), 1, 0); tick();
    drive(mk(32'h5000_0008, 0, 0, 0, 0, 0, 0, 0), idle, 1, 0); tick();
    drive(idle, idle, 0, 0);
    chk("d033_occ3", 64'(occupancy), 64'd3);
    #1 rstn = 1'b0;
    #1;
    chk("d033_occ", 64'(occupancy), 64'd0);
    chk("d033_v1", 64'(out_set1.o_valid), 64'd0);
    chk("d033_v2", 64'(out_set2.o_valid), 64'd0);
    tick();
    rstn = 1'b1;

    // Randomized traffic with stalls and occasional flushes.
    for (int n = 0; n < 3000; n++) begin
      drive(rand_inst(), rand_inst(), ($urandom_range(0, 9) < 3), ($urandom_range(0, 49) == 0));
      tick();
    end
    drive(idle, idle, 0, 0);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
